// File: rtl/shift_mult_ctrl_pkg.sv
// Shared types and constants for the shift/normalise/shift-add multiplier controller.
package shift_mult_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD1 = 3'd1,
      NORM1 = 3'd2,
      LOAD2 = 3'd3,
      NORM2 = 3'd4,
      MUL   = 3'd5,
      DONE  = 3'd6,
      DRAIN = 3'd7
   } state_e;

   localparam int ITER_COUNT         = 16;
   localparam int NORM_LIMIT_DEFAULT = 8;

endpackage

// File: rtl/norm_step_counter.sv
// Normalisation step counter: synchronous clear, increment, and limit compare.
module norm_step_counter #(
   parameter int LIMIT = 8,
   parameter int W     = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic inc_i,
   output logic at_limit_o
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i) begin
         count_d = count_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign at_limit_o = (count_q == W'(LIMIT));

endmodule

// File: rtl/shift_mult_ctrl.sv
// Sequencer for the shift/normalise/shift-add multiplier datapath.
// Define SHIFT_MULT_CTRL_ABORT_EN to add the abort input and the DRAIN state.
module shift_mult_ctrl
   import shift_mult_ctrl_pkg::*;
#(
   parameter int N_EFFECTIVE = 8,
   parameter int NORM_LIMIT  = NORM_LIMIT_DEFAULT,
   parameter int LIM_W       = $clog2(NORM_LIMIT + 1)
) (
   input  logic clk,
   input  logic rst,
`ifdef SHIFT_MULT_CTRL_ABORT_EN
   input  logic abort,
`endif
   input  logic start,
   input  logic half1,
   input  logic half2,
   input  logic co2,
   input  logic co1,
   input  logic lsb2,
   output logic ld1,
   output logic ld2,
   output logic shr1,
   output logic shr2,
   output logic cnt1,
   output logic cnt2,
   output logic busy,
   output logic done,
   output logic zero
);

   if (2 * N_EFFECTIVE != ITER_COUNT) begin : g_width_check
      $error("shift_mult_ctrl: 2*N_EFFECTIVE must equal ITER_COUNT");
   end

   state_e state_q, state_d;
   logic   zero_q, zero_d;
   logic   step_clr, step_inc, step_at_limit;
   logic   abort_req;

`ifdef SHIFT_MULT_CTRL_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   norm_step_counter #(
      .LIMIT (NORM_LIMIT),
      .W     (LIM_W)
   ) u_step (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (step_clr),
      .inc_i      (step_inc),
      .at_limit_o (step_at_limit)
   );

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      zero_d   = zero_q;
      step_clr = 1'b0;
      step_inc = 1'b0;
      ld1      = 1'b0;
      ld2      = 1'b0;
      shr1     = 1'b0;
      shr2     = 1'b0;
      cnt1     = 1'b0;
      cnt2     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD1;
               zero_d  = 1'b0;
            end
         end
         LOAD1: begin
            ld1      = 1'b1;
            step_clr = 1'b1;
            state_d  = abort_req ? IDLE : NORM1;
         end
         NORM1: begin
            if (abort_req) begin
               state_d = IDLE;
            end else if (half1) begin
               state_d = LOAD2;
            end else if (co2 || step_at_limit) begin
               zero_d  = 1'b1;
               state_d = DONE;
            end else begin
               shr1     = 1'b1;
               step_inc = 1'b1;
            end
         end
         LOAD2: begin
            ld2      = 1'b1;
            step_clr = 1'b1;
            state_d  = abort_req ? IDLE : NORM2;
         end
         NORM2: begin
            if (abort_req) begin
               state_d = IDLE;
            end else if (half2) begin
               state_d = MUL;
            end else if (step_at_limit) begin
               zero_d  = 1'b1;
               state_d = DONE;
            end else begin
               shr2     = 1'b1;
               step_inc = 1'b1;
            end
         end
         MUL: begin
            // The iteration in progress always completes, even when aborting.
            cnt1 = 1'b1;
            shr2 = 1'b1;
            cnt2 = lsb2;
            if (co1) begin
               state_d = abort_req ? IDLE : DONE;
            end
`ifdef SHIFT_MULT_CTRL_ABORT_EN
            else if (abort_req) begin
               state_d = DRAIN;
            end
`endif
         end
         DONE: begin
            state_d = IDLE;
         end
`ifdef SHIFT_MULT_CTRL_ABORT_EN
         DRAIN: begin
            cnt1 = 1'b1;
            if (co1) begin
               state_d = IDLE;
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         zero_q  <= zero_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign zero = zero_q;

endmodule

// File: tb/tb_shift_mult_ctrl.sv
// Directed bench for shift_mult_ctrl with a behavioural datapath providing the status flags.
module tb_shift_mult_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic start;
`ifdef SHIFT_MULT_CTRL_ABORT_EN
   logic abort;
`endif
   logic half1, half2, co2, co1, lsb2;
   logic ld1, ld2, shr1, shr2, cnt1, cnt2, busy, done, zero;

   always #5 clk = ~clk;

   shift_mult_ctrl dut (
      .clk   (clk),
      .rst   (rst),
`ifdef SHIFT_MULT_CTRL_ABORT_EN
      .abort (abort),
`endif
      .start (start),
      .half1 (half1),
      .half2 (half2),
      .co2   (co2),
      .co1   (co1),
      .lsb2  (lsb2),
      .ld1   (ld1),
      .ld2   (ld2),
      .shr1  (shr1),
      .shr2  (shr2),
      .cnt1  (cnt1),
      .cnt2  (cnt2),
      .busy  (busy),
      .done  (done),
      .zero  (zero)
   );

   // Datapath model: operand registers, shift-add accumulator, 4-bit iteration counter.
   int          need1, need2;
   bit          op1_zero, co2_force;
   logic [7:0]  op1, op2;
   logic [15:0] m_q, b_q, acc_q;
   logic [3:0]  it_q;
   int          n1_q, n2_q;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q <= '0; b_q <= '0; acc_q <= '0; it_q <= 4'd15; n1_q <= 0; n2_q <= 0;
      end else begin
         if (ld1) begin
            m_q  <= {8'h00, op1};
            n1_q <= 0;
         end
         if (shr1) n1_q <= n1_q + 1;
         if (ld2) begin
            b_q   <= {8'h00, op2};
            acc_q <= '0;
            n2_q  <= 0;
         end
         if (shr2 && !cnt1) n2_q <= n2_q + 1;
         if (shr2 && cnt1) begin
            if (cnt2) acc_q <= acc_q + m_q;
            m_q <= m_q << 1;
            b_q <= b_q >> 1;
         end
         if (cnt1) it_q <= it_q - 4'd1;
      end
   end

   assign half1 = !op1_zero && (n1_q >= need1);
   assign half2 = (n2_q >= need2);
   assign lsb2  = b_q[0];
   assign co1   = (it_q == 4'd0);
   assign co2   = co2_force;

   // Strobe monitor: cumulative counts, differenced around each operation.
   int cyc = 0;
   int n_shr1 = 0, n_ld2 = 0, n_mul = 0, n_shr2n = 0, n_drain = 0, n_done = 0, n_cnt2err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (shr1) n_shr1 <= n_shr1 + 1;
         if (ld2) n_ld2 <= n_ld2 + 1;
         if (cnt1 && shr2) n_mul <= n_mul + 1;
         if (shr2 && !cnt1) n_shr2n <= n_shr2n + 1;
         if (cnt1 && !shr2) n_drain <= n_drain + 1;
         if (done) n_done <= n_done + 1;
         if ((cnt1 && shr2) ? (cnt2 !== lsb2) : (cnt2 !== 1'b0)) n_cnt2err <= n_cnt2err + 1;
      end
   end

   typedef struct {
      int shr1, ld2, mul, shr2n, drain, done, cnt2err;
   } cnt_t;

   function automatic cnt_t snap();
      cnt_t s;
      s.shr1 = n_shr1; s.ld2 = n_ld2; s.mul = n_mul; s.shr2n = n_shr2n;
      s.drain = n_drain; s.done = n_done; s.cnt2err = n_cnt2err;
      return s;
   endfunction

   typedef struct {
      int          need1, need2;
      bit          op1z, co2f;
      logic [7:0]  op1, op2;
      int          lat, shr1, ld2, mul, shr2n;
      bit          zero;
      logic [15:0] prod;
      bit          chk_prod;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic set_ops(input vec_t v);
      need1 = v.need1; need2 = v.need2; op1_zero = v.op1z; co2_force = v.co2f;
      op1 = v.op1; op2 = v.op2;
   endtask

   // Starts one operation; start is high only on the listed cycles after the sample edge.
   task automatic run_op(input string tag, input int p1, input int p2, output int lat);
      int  t0;
      bit  seen;
      seen = 1'b0;
      lat  = -1;
      @(negedge clk);
      start = 1'b1;
      t0    = cyc;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         start = (c == p1) || (c == p2);
         if (done) begin
            lat  = cyc - t0;
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check({tag, " done timeout"}, 0, 1);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_mul(input string tag);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (cnt1 && shr2) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check({tag, " mul timeout"}, 0, 1);
   endtask

   vec_t vecs[8];
   vec_t base;
   cnt_t s0, s1;
   int   lat, c1, c2, nd;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //           n1 n2 z  co2 op1    op2    lat shr1 ld2 mul shr2n zero prod      chk
      vecs[0] = '{0, 0, 0, 0, 8'hA5, 8'h3C, 21, 0, 1, 16, 0, 0, 16'h26AC, 1};
      vecs[1] = '{3, 0, 0, 0, 8'h12, 8'h34, 24, 3, 1, 16, 0, 0, 16'h03A8, 1};
      vecs[2] = '{0, 0, 1, 0, 8'h00, 8'h55, 11, 8, 0, 0,  0, 1, 16'h0000, 0};
      vecs[3] = '{5, 0, 0, 1, 8'h01, 8'h55, 3,  0, 0, 0,  0, 1, 16'h0000, 0};
      vecs[4] = '{0, 2, 0, 0, 8'hFF, 8'hFF, 23, 0, 1, 16, 2, 0, 16'hFE01, 1};
      vecs[5] = '{0, 99,0, 0, 8'hC3, 8'h00, 13, 0, 1, 0,  8, 1, 16'h0000, 0};
      vecs[6] = '{8, 0, 0, 0, 8'h80, 8'h01, 29, 8, 1, 16, 0, 0, 16'h0080, 1};
      vecs[7] = '{0, 2, 0, 1, 8'h80, 8'h7F, 23, 0, 1, 16, 2, 0, 16'h3F80, 1};
      base = vecs[0];

      rst = 1'b1; start = 1'b0;
`ifdef SHIFT_MULT_CTRL_ABORT_EN
      abort = 1'b0;
`endif
      set_ops(base);
      repeat (2) @(negedge clk);
      check("outputs during reset", {ld1, ld2, shr1, shr2, cnt1, cnt2, busy, done, zero}, 0);
      rst = 1'b0;
      @(negedge clk);
      check("outputs first cycle after reset", {ld1, ld2, shr1, shr2, cnt1, cnt2, busy, done, zero}, 0);

      for (int i = 0; i < 8; i++) begin
         set_ops(vecs[i]);
         s0 = snap();
         run_op($sformatf("v%0d", i), 0, 0, lat);
         s1 = snap();
         check($sformatf("v%0d latency", i), lat, vecs[i].lat);
         check($sformatf("v%0d shr1 pulses", i), s1.shr1 - s0.shr1, vecs[i].shr1);
         check($sformatf("v%0d ld2 pulses", i), s1.ld2 - s0.ld2, vecs[i].ld2);
         check($sformatf("v%0d mul cycles", i), s1.mul - s0.mul, vecs[i].mul);
         check($sformatf("v%0d norm2 shifts", i), s1.shr2n - s0.shr2n, vecs[i].shr2n);
         check($sformatf("v%0d done pulses", i), s1.done - s0.done, 1);
         check($sformatf("v%0d cnt2 tracking", i), s1.cnt2err - s0.cnt2err, 0);
         check($sformatf("v%0d stray cnt1", i), s1.drain - s0.drain, 0);
         check($sformatf("v%0d zero", i), zero, vecs[i].zero);
         check($sformatf("v%0d busy after", i), busy, 0);
         check($sformatf("v%0d iter counter", i), it_q, 15);
         if (vecs[i].chk_prod) check($sformatf("v%0d product", i), acc_q, vecs[i].prod);
         if (i == 2) begin
            repeat (3) @(negedge clk);
            check("zero held in idle", zero, 1);
         end
      end

      // start pulses mid-operation and during DONE must be ignored
      set_ops(base);
      s0 = snap();
      run_op("busy start", 5, 21, lat);
      @(negedge clk);
      s1 = snap();
      check("busy start latency", lat, 21);
      check("busy start done pulses", s1.done - s0.done, 1);
      check("busy start idle after", busy, 0);

      // start held high: back-to-back operations
      @(negedge clk);
      start = 1'b1;
      nd = 0; c1 = 0; c2 = 0;
      for (int c = 0; c < 100 && nd < 2; c++) begin
         @(negedge clk);
         if (done) begin
            nd++;
            if (nd == 1) c1 = cyc; else c2 = cyc;
         end
      end
      start = 1'b0;
      check("back-to-back done count", nd, 2);
      check("back-to-back spacing", c2 - c1, 22);
      check("back-to-back product", acc_q, 16'h26AC);
      repeat (25) @(negedge clk);
      check("back-to-back idle after", busy, 0);

      // reset asserted on MUL cycle 7
      @(negedge clk);
      start = 1'b1;
      wait_mul("rst");
      repeat (6) @(negedge clk);
      rst = 1'b1;
      #1;
      check("outputs at mid-mul reset", {ld1, ld2, shr1, shr2, cnt1, cnt2, busy, done, zero}, 0);
      @(negedge clk);
      rst = 1'b0;
      s0 = snap();
      run_op("after rst", 0, 0, lat);
      s1 = snap();
      check("after rst latency", lat, 21);
      check("after rst mul cycles", s1.mul - s0.mul, 16);
      check("after rst product", acc_q, 16'h26AC);

`ifdef SHIFT_MULT_CTRL_ABORT_EN
      // abort on MUL cycle 5: drain the iteration counter without a done pulse
      s0 = snap();
      @(negedge clk);
      start = 1'b1;
      wait_mul("abort");
      repeat (4) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      begin
         bit idle_seen;
         idle_seen = 1'b0;
         for (int c = 0; c < 50; c++) begin
            if (!busy) begin
               idle_seen = 1'b1;
               break;
            end
            @(negedge clk);
         end
         if (!idle_seen) check("abort idle timeout", 0, 1);
      end
      @(negedge clk);
      s1 = snap();
      check("abort mul cycles", s1.mul - s0.mul, 5);
      check("abort drain cycles", s1.drain - s0.drain, 11);
      check("abort done pulses", s1.done - s0.done, 0);
      check("abort iter counter", it_q, 15);
      s0 = snap();
      run_op("post abort", 0, 0, lat);
      s1 = snap();
      check("post abort latency", lat, 21);
      check("post abort mul cycles", s1.mul - s0.mul, 16);
      check("post abort product", acc_q, 16'h26AC);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
